// File: rtl/wb_regfile_if.sv
// Write-back stage bus: MEM/WB pipeline inputs, ID-stage read ports and
// forwarding/debug outputs of the register file.
interface wb_regfile_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
);
  logic [DATA_W-1:0] IMemData;
  logic [DATA_W-1:0] IALUOut;
  logic [DATA_W-1:0] IPCAdd4;
  logic [ADDR_W-1:0] IWriteReg;
  logic              ICRegWrite;
  logic [1:0]        ICMemtoReg;
  logic [ADDR_W-1:0] RdAddr1;
  logic [ADDR_W-1:0] RdAddr2;
  logic [DATA_W-1:0] RdData1;
  logic [DATA_W-1:0] RdData2;
  logic [DATA_W-1:0] OWBData;
  logic [ADDR_W-1:0] OWBReg;
  logic              OWBEn;
  logic [CNT_W-1:0]  OWriteCount;

  modport master (
    output IMemData, IALUOut, IPCAdd4, IWriteReg, ICRegWrite, ICMemtoReg,
           RdAddr1, RdAddr2,
    input  RdData1, RdData2, OWBData, OWBReg, OWBEn, OWriteCount
  );

  modport slave (
    input  IMemData, IALUOut, IPCAdd4, IWriteReg, ICRegWrite, ICMemtoReg,
           RdAddr1, RdAddr2,
    output RdData1, RdData2, OWBData, OWBReg, OWBEn, OWriteCount
  );
endinterface

// File: rtl/wb_regfile.sv
// Write-back mux, 2**ADDR_W-entry register file with write-first bypassed
// read ports, and a retired-write counter.

module wb_rdport #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic [ADDR_W-1:0]                     rdAddr,
  input  logic [2**ADDR_W-1:0][DATA_W-1:0]      regs,
  input  logic                                  wbEn,
  input  logic [ADDR_W-1:0]                     wbReg,
  input  logic [DATA_W-1:0]                     wbData,
  output logic [DATA_W-1:0]                     rdData
);
  always_comb begin
    rdData = regs[rdAddr];
    if (rdAddr == '0)                       rdData = '0;
    else if (wbEn && (rdAddr == wbReg))     rdData = wbData;
  end
endmodule

module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
) (
  input  logic        clk,
  input  logic        reset,
  wb_regfile_if.slave bus
);
  localparam int NREG = 2**ADDR_W;
  localparam int NRD  = 2;

  logic [NREG-1:0][DATA_W-1:0] regs;
  logic [CNT_W-1:0]            writeCount;
  logic [DATA_W-1:0]           wbData;
  logic                        wbEn;
  logic [NRD-1:0][ADDR_W-1:0]  rdAddr;
  logic [NRD-1:0][DATA_W-1:0]  rdData;

  // Encoding 11 is reserved and falls back to the ALU result.
  always_comb begin
    case (bus.ICMemtoReg)
      2'b01:   wbData = bus.IMemData;
      2'b10:   wbData = bus.IPCAdd4;
      default: wbData = bus.IALUOut;
    endcase
  end

  assign wbEn            = bus.ICRegWrite && (bus.IWriteReg != '0);
  assign bus.OWBData     = wbData;
  assign bus.OWBEn       = wbEn;
  assign bus.OWBReg      = wbEn ? bus.IWriteReg : '0;
  assign bus.OWriteCount = writeCount;

  // Entry 0 is never written, so it holds its reset value forever.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      regs       <= '0;
      writeCount <= '0;
    end else if (wbEn) begin
      regs[bus.IWriteReg] <= wbData;
      writeCount          <= writeCount + CNT_W'(1);
    end
  end

  assign rdAddr = {bus.RdAddr2, bus.RdAddr1};

  for (genvar p = 0; p < NRD; p++) begin : gRd
    wb_rdport #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) uRd (
      .rdAddr (rdAddr[p]),
      .regs   (regs),
      .wbEn   (wbEn),
      .wbReg  (bus.IWriteReg),
      .wbData (wbData),
      .rdData (rdData[p])
    );
  end

  assign bus.RdData1 = rdData[0];
  assign bus.RdData2 = rdData[1];
endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: a driver pushes expected responses from a
// plain array model, a negedge monitor pops and compares.
module tb_wb_regfile;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  wb_regfile_if bus ();
  wb_regfile_if #(.CNT_W(3)) busW ();

  // Narrow-counter copy sees identical stimulus so wrap-around is reachable.
  assign busW.IMemData   = bus.IMemData;
  assign busW.IALUOut    = bus.IALUOut;
  assign busW.IPCAdd4    = bus.IPCAdd4;
  assign busW.IWriteReg  = bus.IWriteReg;
  assign busW.ICRegWrite = bus.ICRegWrite;
  assign busW.ICMemtoReg = bus.ICMemtoReg;
  assign busW.RdAddr1    = bus.RdAddr1;
  assign busW.RdAddr2    = bus.RdAddr2;

  wb_regfile uDut (.clk(clk), .reset(reset), .bus(bus));
  wb_regfile #(.CNT_W(3)) uDutW (.clk(clk), .reset(reset), .bus(busW));

  typedef struct {
    logic [31:0] rd1, rd2, wbData, cnt;
    logic [4:0]  wbReg;
    logic        wbEn;
    logic [2:0]  cntW;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int nCmp = 0, nBad = 0;

  bit [31:0] mReg [32];
  bit [31:0] mCnt = 0;
  bit        pEn = 0;
  bit [4:0]  pWr = 0;
  bit [31:0] pVal = 0;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
    nCmp++;
    if (act !== req) begin
      nBad++;
      $display("FAIL %s: got %h required %h (t=%0t)", n, act, req, $time);
    end
  endtask

  function automatic bit [31:0] mRead(input bit [4:0] a, input bit en,
                                      input bit [4:0] wr, input bit [31:0] val);
    if (a == 0) return 0;
    if (en && a == wr) return val;
    return mReg[a];
  endfunction

  task automatic step(input bit rst, input bit [31:0] mem, input bit [31:0] alu,
                      input bit [31:0] pc, input bit [4:0] wr, input bit we,
                      input bit [1:0] sel, input bit [4:0] a1, input bit [4:0] a2);
    bit [31:0] val;
    bit en;
    exp_t x;
    @(posedge clk); #1;
    if (reset && pEn) begin
      mReg[pWr] = pVal;
      mCnt++;
    end
    reset = rst;
    if (!rst) begin
      foreach (mReg[i]) mReg[i] = 0;
      mCnt = 0;
    end
    bus.IMemData = mem; bus.IALUOut = alu; bus.IPCAdd4 = pc;
    bus.IWriteReg = wr; bus.ICRegWrite = we; bus.ICMemtoReg = sel;
    bus.RdAddr1 = a1; bus.RdAddr2 = a2;
    val = (sel == 2'd1) ? mem : (sel == 2'd2) ? pc : alu;
    en  = we && (wr != 0);
    x.rd1 = mRead(a1, en, wr, val);
    x.rd2 = mRead(a2, en, wr, val);
    x.wbData = val;
    x.wbReg = en ? wr : 5'd0;
    x.wbEn = en;
    x.cnt = mCnt;
    x.cntW = 3'(mCnt % 8);
    q.push_back(x);
    pEn = en; pWr = wr; pVal = val;
  endtask

  task automatic randStep(input bit rst);
    step(rst, $urandom, $urandom, $urandom, 5'($urandom), 1'($urandom_range(0, 3) != 0),
         2'($urandom), 5'($urandom), 5'($urandom));
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("RdData1", bus.RdData1, e.rd1);
      chk("RdData2", bus.RdData2, e.rd2);
      chk("OWBData", bus.OWBData, e.wbData);
      chk("OWBReg", 32'(bus.OWBReg), 32'(e.wbReg));
      chk("OWBEn", 32'(bus.OWBEn), 32'(e.wbEn));
      chk("OWriteCount", bus.OWriteCount, e.cnt);
      chk("OWriteCountNarrow", 32'(busW.OWriteCount), 32'(e.cntW));
    end
  end

  initial begin
    bus.IMemData = 0; bus.IALUOut = 0; bus.IPCAdd4 = 0; bus.IWriteReg = 0;
    bus.ICRegWrite = 0; bus.ICMemtoReg = 0; bus.RdAddr1 = 0; bus.RdAddr2 = 0;
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // After reset every index reads zero.
    for (int i = 0; i < 32; i++)
      step(1, $urandom, $urandom, $urandom, 5'($urandom), 0, 2'($urandom), 5'(i), 5'(31 - i));
    step(1, 32'h0, 32'h1234_5678, 32'h0, 5, 1, 2'b00, 5, 0);
    step(1, 32'hDEAD_BEEF, 32'h1111_2222, 32'h0, 8, 1, 2'b01, 8, 8);
    step(1, 32'h0, 32'hFFFF_FFFF, 32'h0, 0, 1, 2'b00, 0, 5);
    step(1, 32'h0, 32'h0, 32'h0, 0, 0, 2'b00, 0, 8);
    step(1, 32'h9999_0000, 32'h7777_0000, 32'h0040_0008, 31, 1, 2'b10, 31, 5);
    step(1, 32'h9999_0001, 32'hA5A5_0001, 32'h0040_000C, 31, 1, 2'b11, 0, 31);
    step(1, 32'h0, 32'h0, 32'h0, 0, 0, 2'b00, 31, 8);
    repeat (400) randStep($urandom_range(0, 49) != 0);
    // Reset arrives while a write is pending; bypass still shows the value.
    step(1, 32'h0, 32'hCAFE_0009, 32'h0, 9, 1, 2'b00, 9, 5);
    step(0, 32'h0, 32'hBEEF_0009, 32'h0, 9, 1, 2'b00, 9, 8);
    step(0, 32'h0, 32'h0, 32'h0, 0, 0, 2'b00, 5, 9);
    step(1, 32'h0, 32'h0303_0303, 32'h0, 3, 1, 2'b00, 9, 3);
    step(1, 32'h0, 32'h0, 32'h0, 0, 0, 2'b00, 3, 9);
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    @(posedge clk);
    chk("ScoreboardDrained", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end
endmodule
